// File: rtl/pa_lsu_vb_ctrl_if.sv
// Victim-buffer control bundle: dcache create/fill, entry status, clear and BIU writeback handshakes.
// master = pa_lsu_vb_ctrl; slave = the dcache / VB entry / BIU side.
interface pa_lsu_vb_ctrl_if #(
  parameter int VB_NUM = 2,
  parameter int IDX_W  = 1
);
  logic              rtu_yy_xx_async_flush;
  logic              dc_vb_create_req;
  logic              vb_dc_create_gnt;
  logic [VB_NUM-1:0] vb_create_en_x;
  logic              dc_vb_data_vld;
  logic [1:0]        vb_create_data_cnt;
  logic [VB_NUM-1:0] vb_entry_vld_x;
  logic [VB_NUM-1:0] vb_entry_biu_req_x;
  logic              vb_clr_req;
  logic [VB_NUM-1:0] vb_clr_en_x;
  logic              vb_biu_req;
  logic [IDX_W-1:0]  vb_biu_idx;
  logic              biu_vb_grant;
  logic              biu_vb_cmplt;
  logic [VB_NUM-1:0] vb_wb_grant_x;
  logic [VB_NUM-1:0] vb_wb_cmplt_x;
  logic              vb_full;
  logic              vb_empty;

  modport master (
    input  rtu_yy_xx_async_flush, dc_vb_create_req, dc_vb_data_vld, vb_entry_vld_x,
           vb_entry_biu_req_x, vb_clr_req, biu_vb_grant, biu_vb_cmplt,
    output vb_dc_create_gnt, vb_create_en_x, vb_create_data_cnt, vb_clr_en_x,
           vb_biu_req, vb_biu_idx, vb_wb_grant_x, vb_wb_cmplt_x, vb_full, vb_empty
  );

  modport slave (
    output rtu_yy_xx_async_flush, dc_vb_create_req, dc_vb_data_vld, vb_entry_vld_x,
           vb_entry_biu_req_x, vb_clr_req, biu_vb_grant, biu_vb_cmplt,
    input  vb_dc_create_gnt, vb_create_en_x, vb_create_data_cnt, vb_clr_en_x,
           vb_biu_req, vb_biu_idx, vb_wb_grant_x, vb_wb_cmplt_x, vb_full, vb_empty
  );
endinterface

// File: rtl/pa_lsu_vb_ctrl.sv
// LSU victim-buffer control: entry allocation + 4-beat fill sequencing, BIU writeback arbitration, clear/status.
// Latency: create grant/allocate combinational; BIU request one cycle after an entry asks; pulses coincide with BIU grant/cmplt.
// Backpressure: dcache holds create while full or filling; PA_LSU_VB_RR_ARB_EN selects round-robin over fixed-priority writeback.
module pa_lsu_vb_ctrl #(
  parameter int VB_NUM = 2,
  parameter int IDX_W  = 1
) (
  input  logic                  vb_clk,
  input  logic                  cpurst_b,
  pa_lsu_vb_ctrl_if.master      vb_if
);

  typedef enum logic {F_IDLE, F_FILL} fill_st_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wb_st_t;

  fill_st_t          fill_st, fill_nxt;
  logic [1:0]        cnt, cnt_nxt;
  wb_st_t            wb_st, wb_nxt;
  logic [IDX_W-1:0]  wb_idx, wb_idx_nxt;
  logic [IDX_W-1:0]  arb_idx;
  logic [VB_NUM-1:0] free_oh;
  logic [VB_NUM-1:0] grant_x, cmplt_x;
  logic              create_gnt, biu_req, flush, full;

  assign flush = vb_if.rtu_yy_xx_async_flush;
  assign full  = &vb_if.vb_entry_vld_x;

  // Lowest-index free entry, one-hot.
  always_comb begin
    free_oh = '0;
    for (int i = VB_NUM - 1; i >= 0; i--) begin
      if (!vb_if.vb_entry_vld_x[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

`ifdef PA_LSU_VB_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   rr_cand;

  // Walk from ptr+1 around the ring; the last hit in the downward loop is the nearest one.
  always_comb begin
    arb_idx = '0;
    rr_cand = '0;
    for (int k = VB_NUM; k >= 1; k--) begin
      rr_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rr_cand >= (IDX_W+1)'(VB_NUM)) rr_cand = rr_cand - (IDX_W+1)'(VB_NUM);
      if (vb_if.vb_entry_biu_req_x[rr_cand[IDX_W-1:0]]) arb_idx = rr_cand[IDX_W-1:0];
    end
  end

  always_ff @(posedge vb_clk) begin
    if (!cpurst_b)     rr_ptr <= '0;
    else if (|grant_x) rr_ptr <= wb_idx;
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = VB_NUM - 1; i >= 0; i--) begin
      if (vb_if.vb_entry_biu_req_x[i]) arb_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    fill_nxt   = fill_st;
    cnt_nxt    = cnt;
    create_gnt = 1'b0;
    case (fill_st)
      F_IDLE: begin
        create_gnt = vb_if.dc_vb_create_req & ~full & ~flush;
        if (create_gnt) begin
          fill_nxt = F_FILL;
          cnt_nxt  = 2'd0;
        end
      end
      F_FILL: begin
        if (vb_if.dc_vb_data_vld) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) fill_nxt = F_IDLE;
        end
      end
      default: fill_nxt = F_IDLE;
    endcase
    if (flush) begin
      fill_nxt = F_IDLE;
      cnt_nxt  = 2'd0;
    end
  end

  always_comb begin
    wb_nxt     = wb_st;
    wb_idx_nxt = wb_idx;
    biu_req    = 1'b0;
    grant_x    = '0;
    cmplt_x    = '0;
    case (wb_st)
      W_IDLE: begin
        if (|vb_if.vb_entry_biu_req_x) begin
          wb_nxt     = W_REQ;
          wb_idx_nxt = arb_idx;
        end
      end
      W_REQ: begin
        biu_req = 1'b1;
        // A cmplt arriving with the grant is illegal on the BIU and is dropped here.
        if (vb_if.biu_vb_grant) begin
          grant_x[wb_idx] = 1'b1;
          wb_nxt          = W_WAIT;
        end
      end
      W_WAIT: begin
        if (vb_if.biu_vb_cmplt) begin
          cmplt_x[wb_idx] = 1'b1;
          wb_nxt          = W_IDLE;
        end
      end
      default: wb_nxt = W_IDLE;
    endcase
    if (flush) begin
      wb_nxt     = W_IDLE;
      wb_idx_nxt = wb_idx;
      biu_req    = 1'b0;
      grant_x    = '0;
      cmplt_x    = '0;
    end
  end

  always_ff @(posedge vb_clk) begin
    if (!cpurst_b) begin
      fill_st <= F_IDLE;
      cnt     <= 2'd0;
      wb_st   <= W_IDLE;
      wb_idx  <= '0;
    end else begin
      fill_st <= fill_nxt;
      cnt     <= cnt_nxt;
      wb_st   <= wb_nxt;
      wb_idx  <= wb_idx_nxt;
    end
  end

  assign vb_if.vb_dc_create_gnt   = create_gnt;
  assign vb_if.vb_create_en_x     = create_gnt ? free_oh : '0;
  assign vb_if.vb_create_data_cnt = cnt;
  assign vb_if.vb_clr_en_x        = {VB_NUM{vb_if.vb_clr_req}};
  assign vb_if.vb_biu_req         = biu_req;
  assign vb_if.vb_biu_idx         = wb_idx;
  assign vb_if.vb_wb_grant_x      = grant_x;
  assign vb_if.vb_wb_cmplt_x      = cmplt_x;
  assign vb_if.vb_full            = full;
  assign vb_if.vb_empty           = ~|vb_if.vb_entry_vld_x;

endmodule
